// File: rtl/pc_next_unit.sv
// Program-counter stage: computes PC+4, branch/jump/jr targets and owns the PC register.
// A redirect that arrives while fetch cannot advance is parked until imem/stall allow it.
module pc_next_unit #(
    parameter int unsigned  n        = 32,
    parameter logic [n-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         imem_ready,
    input  logic         branch_taken,
    input  logic [n-1:0] branch_offset,
    input  logic         jump,
    input  logic [25:0]  jump_index,
    input  logic         jr,
    input  logic [n-1:0] jr_target,
    output logic         imem_req,
    output logic [n-1:0] pc,
    output logic [n-1:0] pc_plus4,
    output logic         flush,
    output logic         redir_pending,
    output logic         misaligned
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [n-1:0] pc_q, pc_d;
    logic [n-1:0] pend_q, pend_d;
    logic         misaligned_q, misaligned_d;

    logic [n-1:0] pc_plus4_w;
    logic [n-1:0] br_tgt, j_tgt, jr_tgt, sel_tgt;
    logic         redirect, advance;

    assign pc_plus4_w = pc_q + {{(n-3){1'b0}}, 3'd4};
    assign br_tgt     = pc_plus4_w + branch_offset;
    assign j_tgt      = {pc_plus4_w[n-1:28], jump_index, 2'b00};
    assign jr_tgt     = {jr_target[n-1:2], 2'b00};
    assign redirect   = jr | jump | branch_taken;
    assign advance    = imem_ready & ~stall;

    // jr outranks jump, which outranks a taken branch
    always_comb begin
        sel_tgt = br_tgt;
        if (jr) begin
            sel_tgt = jr_tgt;
        end else if (jump) begin
            sel_tgt = j_tgt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            pend_q       <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            misaligned_q <= misaligned_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        misaligned_d = misaligned_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (jr && (jr_target[1:0] != 2'b00)) begin
                    misaligned_d = 1'b1;
                end
                if (advance) begin
                    pc_d = redirect ? sel_tgt : pc_plus4_w;
                end else if (redirect) begin
                    pend_d  = sel_tgt;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // later redirects are dropped; the parked one is applied first
                if (advance) begin
                    pc_d    = pend_q;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_comb begin
        imem_req      = (state_q != ST_BOOT);
        flush         = (state_q == ST_FETCH) && redirect;
        redir_pending = (state_q == ST_HOLD);
    end

    assign pc         = pc_q;
    assign pc_plus4   = pc_plus4_w;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: a cycle model pushes expected post-edge state to a queue,
// which is popped and compared one cycle later; directed tasks add fixed-value checks.
module tb_pc_next_unit;

    localparam logic [1:0] M_BOOT = 2'd0, M_FETCH = 2'd1, M_HOLD = 2'd2;

    logic        clk = 1'b0;
    logic        reset, stall, imem_ready, branch_taken, jump, jr;
    logic [31:0] branch_offset, jr_target;
    logic [25:0] jump_index;
    logic        imem_req, flush, redir_pending, misaligned;
    logic [31:0] pc, pc_plus4;

    typedef struct {
        logic [31:0] pc;
        logic        pend;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [1:0]  m_state;
    logic [31:0] m_pc, m_pend;
    logic        m_mis;

    pc_next_unit #(.n(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .stall(stall), .imem_ready(imem_ready),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_index(jump_index), .jr(jr), .jr_target(jr_target),
        .imem_req(imem_req), .pc(pc), .pc_plus4(pc_plus4), .flush(flush),
        .redir_pending(redir_pending), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_state = M_BOOT;
        m_pc    = 32'h0;
        m_pend  = 32'h0;
        m_mis   = 1'b0;
        sb.delete();
    endtask

    // One clock cycle: drive inputs, check combinational outputs mid-cycle,
    // predict the post-edge state, then compare it after the edge.
    task automatic step(input logic st, input logic rdy, input logic br,
                        input logic [31:0] off, input logic jp,
                        input logic [25:0] idx, input logic jrq,
                        input logic [31:0] jrt);
        exp_t        e;
        logic        adv, redir;
        logic [31:0] p4, tgt;
        stall = st; imem_ready = rdy; branch_taken = br; branch_offset = off;
        jump = jp; jump_index = idx; jr = jrq; jr_target = jrt;
        @(negedge clk);
        p4    = m_pc + 32'd4;
        redir = jrq | jp | br;
        adv   = rdy & ~st;
        n_cmp++;
        if (imem_req !== (m_state != M_BOOT)) begin
            n_bad++;
            $display("FAIL imem_req: got %b expected %b", imem_req, m_state != M_BOOT);
        end
        n_cmp++;
        if (flush !== ((m_state == M_FETCH) && redir)) begin
            n_bad++;
            $display("FAIL flush: got %b expected %b", flush, (m_state == M_FETCH) && redir);
        end
        n_cmp++;
        if (pc_plus4 !== p4) begin
            n_bad++;
            $display("FAIL pc_plus4: got %h expected %h", pc_plus4, p4);
        end
        if (jrq)      tgt = {jrt[31:2], 2'b00};
        else if (jp)  tgt = {p4[31:28], idx, 2'b00};
        else          tgt = p4 + off;
        if (m_state == M_BOOT) begin
            m_state = M_FETCH;
        end else if (m_state == M_FETCH) begin
            if (jrq && jrt[1:0] != 2'b00) m_mis = 1'b1;
            if (adv) m_pc = redir ? tgt : p4;
            else if (redir) begin
                m_pend  = tgt;
                m_state = M_HOLD;
            end
        end else if (adv) begin
            m_pc    = m_pend;
            m_state = M_FETCH;
        end
        e.pc = m_pc; e.pend = (m_state == M_HOLD); e.mis = m_mis;
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        n_cmp++;
        if (pc !== e.pc) begin
            n_bad++;
            $display("FAIL pc: got %h expected %h", pc, e.pc);
        end
        n_cmp++;
        if (redir_pending !== e.pend) begin
            n_bad++;
            $display("FAIL redir_pending: got %b expected %b", redir_pending, e.pend);
        end
        n_cmp++;
        if (misaligned !== e.mis) begin
            n_bad++;
            $display("FAIL misaligned: got %b expected %b", misaligned, e.mis);
        end
    endtask

    task automatic adv_cycle();
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    endtask

    task automatic jr_to(input logic [31:0] a);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, a);
    endtask

    task automatic expect_pc(input string name, input logic [31:0] want);
        n_cmp++;
        if (pc !== want) begin
            n_bad++;
            $display("FAIL %s: pc got %h expected %h", name, pc, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; imem_ready = 1'b1; branch_taken = 1'b0;
        branch_offset = 32'h0; jump = 1'b0; jump_index = 26'h0; jr = 1'b0; jr_target = 32'h0;
        model_reset();
        #13;
        n_cmp++;
        if ({imem_req, flush, redir_pending, misaligned} !== 4'b0000 || pc !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_values: req/flush/pend/mis=%b pc=%h expected 0000 pc=0",
                     {imem_req, flush, redir_pending, misaligned}, pc);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        step(1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 26'h3, 1'b1, 32'h44); // BOOT ignores redirects
        expect_pc("boot_hold", 32'h0);
        adv_cycle(); adv_cycle(); adv_cycle();
        expect_pc("seq_0xC", 32'hC);
    endtask

    task automatic test_branch();
        jr_to(32'h100);
        expect_pc("jr_0x100", 32'h100);
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF0, 1'b0, 26'h0, 1'b0, 32'h0);
        expect_pc("branch_back", 32'h0F4);
    endtask

    task automatic test_jump_priority();
        jr_to(32'h1000_0000);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0800, 1'b1, 26'h0000040, 1'b0, 32'h0);
        expect_pc("jump_over_branch", 32'h1000_0100);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0800, 1'b1, 26'h0000040, 1'b1, 32'h0000_0300);
        expect_pc("jr_over_jump", 32'h0000_0300);
    endtask

    task automatic test_hold();
        jr_to(32'h20);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h83);
        expect_pc("hold_pc", 32'h20);
        n_cmp++;
        if (redir_pending !== 1'b1 || misaligned !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_flags: pend=%b mis=%b expected 1 1", redir_pending, misaligned);
        end
        step(1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 26'h0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 26'h0, 1'b0, 32'h0);
        expect_pc("hold_release", 32'h80);
    endtask

    task automatic test_wrap();
        jr_to(32'hFFFF_FFFC);
        n_cmp++;
        if (pc_plus4 !== 32'h0) begin
            n_bad++;
            $display("FAIL wrap_plus4: got %h expected 00000000", pc_plus4);
        end
        adv_cycle();
        expect_pc("wrap_pc", 32'h0);
    endtask

    task automatic test_stall();
        jr_to(32'h500);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        expect_pc("stall_hold", 32'h500);
        step(1'b1, 1'b1, 1'b1, 32'h10, 1'b0, 26'h0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 26'h7, 1'b0, 32'h0);
        expect_pc("stall_redirect", 32'h514);
    endtask

    task automatic test_back_to_back();
        logic        st, rdy, br, jp, jrq;
        logic [31:0] off, jrt;
        logic [25:0] idx;
        for (int i = 0; i < 200; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            br  = ($urandom_range(0, 3) == 0);
            jp  = ($urandom_range(0, 7) == 0);
            jrq = ($urandom_range(0, 7) == 0);
            off = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            idx = 26'($urandom);
            jrt = $urandom;
            step(st, rdy, br, off, jp, idx, jrq, jrt);
        end
    endtask

    task automatic test_reset_mid_hold();
        jr_to(32'h40);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h200);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({imem_req, flush, redir_pending, misaligned} !== 4'b0000 || pc !== 32'h0) begin
            n_bad++;
            $display("FAIL async_reset: req/flush/pend/mis=%b pc=%h expected 0000 pc=0",
                     {imem_req, flush, redir_pending, misaligned}, pc);
        end
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        adv_cycle();
        expect_pc("no_stale_redirect", 32'h4);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump_priority();
        test_hold();
        test_wrap();
        test_stall();
        test_back_to_back();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Program-counter stage sitting directly downstream of the shift-left-by-2 unit.
- Consumes the word-scaled branch offset from that unit, computes the PC+4, branch and jump targets, and holds the architectural PC register.
- Handshakes with instruction memory and buffers one redirect while fetch is stalled.
- Drives imem address, pc_plus4 to the datapath, and a flush strobe to decode.

Parameters:
- n, 32, datapath/PC width in bits (n >= 30).
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- stall  input  1  downstream hazard stall; PC must not advance while high
- imem_ready  input  1  instruction memory has returned the word at pc this cycle
- branch_taken  input  1  conditional branch resolved taken this cycle
- branch_offset  input  n  sign-extended immediate already shifted left by 2 (sl2 output)
- jump  input  1  J/JAL request this cycle
- jump_index  input  26  instr[25:0] jump field
- jr  input  1  register-indirect jump request this cycle
- jr_target  input  n  register value for jr
- imem_req  output  1  fetch request valid, address = pc
- pc  output  n  current fetch address
- pc_plus4  output  n  pc + 4, to link register / branch adder
- flush  output  1  one-cycle strobe: redirect accepted, squash fetched instruction
- redir_pending  output  1  a redirect is latched and not yet applied
- misaligned  output  1  sticky: a jr target had bits [1:0] != 0

Behaviour:
- Reset (async, immediate): pc=RESET_PC, state=BOOT, imem_req=0, flush=0, redir_pending=0, misaligned=0, pending target reg=0.
- States: BOOT -> FETCH after exactly one clock; FETCH <-> HOLD.
- BOOT: imem_req=0, pc held; redirect inputs ignored.
- Arithmetic, all modulo 2^n, wrap silently:
  - pc_plus4 = pc + 4 (combinational from pc)
  - br_tgt = pc_plus4 + branch_offset
  - j_tgt = {pc_plus4[n-1:28], jump_index, 2'b00}
  - jr_tgt = {jr_target[n-1:2], 2'b00}
- Redirect priority when several requests are asserted: jr > jump > branch_taken.
- advance = imem_ready & ~stall.
- FETCH: imem_req=1.
  - advance & redirect: pc <= selected target next edge; flush=1 that cycle.
  - advance & no redirect: pc <= pc_plus4.
  - ~advance & redirect: latch target into pending reg; flush=1; go to HOLD; pc unchanged.
  - ~advance & no redirect: pc held.
- HOLD: imem_req=1, redir_pending=1, pc held.
  - New redirect inputs are ignored (first redirect wins); flush=0.
  - On advance: pc <= pending target, redir_pending clears next edge, return to FETCH.
- misaligned: set on the edge where a jr with jr_target[1:0]!=0 is accepted (applied or latched). Cleared only by reset. PC still takes the aligned jr_tgt.
- Latency: one cycle from an accepted redirect (with advance) to new pc visible.
- Reset mid-HOLD: pending redirect is discarded; pc=RESET_PC.
- flush is combinational on the acceptance cycle and never asserts in BOOT or HOLD.

Test Plan:
- Reset with RESET_PC=0, no stalls, imem_ready=1 -> BOOT 1 cycle (imem_req=0), then pc 0x0, 0x4, 0x8, 0xC on successive edges.
- pc=0x100, branch_taken=1, branch_offset=0xFFFF_FFF0 -> flush=1; next pc=0x0F4.
- pc=0x1000_0000, jump=1, jump_index=0x0000040, plus branch_taken=1 -> jump wins; next pc=0x1000_0100.
- imem_ready=0, pc=0x20, jr=1, jr_target=0x83 -> flush=1, redir_pending=1, misaligned=1, pc stays 0x20. Next cycle branch_taken=1 is ignored. imem_ready=1 -> pc=0x80, redir_pending=0.
- pc=0xFFFF_FFFC, no redirect, advance -> pc wraps to 0x0. pc_plus4 at 0xFFFF_FFFC reads 0x0.
- In HOLD, assert reset mid-cycle -> outputs go to reset values immediately without waiting for clk; pending target is not applied after reset release.
